// File: rtl/alu_pkg.sv
// Opcode, FSM state and flag encodings shared by alu_seq and its iterative unit.
// Build option: define ALU_SEQ_DIV_EN to make opcode 100 an iterative divider.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_MUL = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_DIV = 3'b100,
        OP_GT  = 3'b101,
        OP_LT  = 3'b110,
        OP_SHL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic z;
        logic a_gt;
        logic b_gt;
    } cmp_flags_t;

    // Opcodes that go through the bit-serial unit instead of the one-cycle path.
    function automatic logic op_is_iter(input alu_op_e op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial unit: shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider,
// one bit per cycle for WIDTH cycles; done_c/result_c are valid in the last step's cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    // acc: product accumulator / partial remainder; x: multiplicand / quotient; y: multiplier / divisor
    logic [WIDTH-1:0] acc_q, x_q, y_q;
    logic [WIDTH-1:0] acc_d, x_d, y_d;

`ifdef ALU_SEQ_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   rem_sh_c;
    logic             ge_c;

    assign rem_sh_c = {acc_q, x_q[WIDTH-1]};
    assign ge_c     = rem_sh_c >= {1'b0, y_q};
`endif

    assign done_c = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    // One iteration of the selected algorithm
    always_comb begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
            acc_d = ge_c ? WIDTH'(rem_sh_c - {1'b0, y_q}) : rem_sh_c[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], ge_c};
            y_d   = y_q;
        end
        result_c = div_q ? x_d : acc_d;
`else
        result_c = acc_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= a;
            y_q    <= b;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= is_div;
`endif
        end else if (busy_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: one-cycle ops plus bit-serial mul/div.
// Build option: ALU_SEQ_DIV_EN selects the iterative divider for opcode 100 (else A>>1).
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in_1,
    input  logic [WIDTH-1:0] d_in_2,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             z_flag,
    output logic             a_grt_b,
    output logic             b_grt_a,
    output logic             div_err
);

    state_e           state_q, state_d;
    alu_op_e          op_c;
    logic             iter_c, div_zero_c;
    logic             accept_c, start_c, load_single_c, load_iter_c;
    logic             iter_done_c;
    logic [WIDTH-1:0] single_res_c, iter_res_c;
    cmp_flags_t       flags_q;

    assign op_c = alu_op_e'(alu_op);

`ifdef ALU_SEQ_DIV_EN
    assign div_zero_c = (op_c == OP_DIV) && (d_in_2 == '0);
`else
    assign div_zero_c = 1'b0;
`endif

    // Divide by zero is resolved on the one-cycle path
    assign iter_c = op_is_iter(op_c) && !div_zero_c;

    alu_muldiv_iter #(
        .WIDTH    (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
`ifdef ALU_SEQ_DIV_EN
        .is_div   (op_c == OP_DIV),
`endif
        .a        (d_in_1),
        .b        (d_in_2),
        .done_c   (iter_done_c),
        .result_c (iter_res_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)    state_d = iter_c ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done_c) state_d = ST_DONE;
            ST_DONE: if (out_ready)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept_c      = 1'b0;
        start_c       = 1'b0;
        load_single_c = 1'b0;
        load_iter_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept_c      = in_valid;
                start_c       = in_valid && iter_c;
                load_single_c = in_valid && !iter_c;
            end
            ST_BUSY: load_iter_c = iter_done_c;
            default: ;
        endcase
    end

    // One-cycle datapath, evaluated on the operands being accepted
    always_comb begin
        single_res_c = '0;
        case (op_c)
            OP_ADD:  single_res_c = d_in_1 + d_in_2;
            OP_AND:  single_res_c = d_in_1 & d_in_2;
            OP_OR:   single_res_c = d_in_1 | d_in_2;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV:  single_res_c = '1;
`else
            OP_DIV:  single_res_c = d_in_1 >> 1;
`endif
            OP_GT:   single_res_c = WIDTH'(d_in_1 > d_in_2);
            OP_LT:   single_res_c = WIDTH'(d_in_1 < d_in_2);
            OP_SHL:  single_res_c = (d_in_2 >= WIDTH'(WIDTH)) ? '0 : (d_in_1 << d_in_2);
            default: single_res_c = '0;
        endcase
    end

    // Output registers; result and flags hold until the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d_out     <= '0;
            flags_q   <= '0;
            div_err   <= 1'b0;
        end else begin
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            if (accept_c) begin
                flags_q.z    <= (d_in_1 == d_in_2);
                flags_q.a_gt <= (d_in_1 > d_in_2);
                flags_q.b_gt <= (d_in_1 < d_in_2);
            end
            if (load_single_c) begin
                d_out   <= single_res_c;
                div_err <= div_zero_c;
            end else if (load_iter_c) begin
                d_out   <= iter_res_c;
                div_err <= 1'b0;
            end
        end
    end

    assign z_flag  = flags_q.z;
    assign a_grt_b = flags_q.a_gt;
    assign b_grt_a = flags_q.b_gt;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed cases plus randomized traffic with backpressure.
// Honours ALU_SEQ_DIV_EN in its reference model.
module tb_alu_seq;

    localparam int unsigned W = 16;
    localparam longint unsigned MOD = 64'd1 << W;

    typedef struct {
        logic [W-1:0] d;
        logic         z;
        logic         gt;
        logic         lt;
        logic         err;
        int           lat;
        int           acc_cyc;
        bit           seen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d_in_1;
    logic [W-1:0] d_in_2;
    logic [2:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d_out;
    logic         z_flag;
    logic         a_grt_b;
    logic         b_grt_a;
    logic         div_err;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   bp_mode = 1;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in_1    (d_in_1),
        .d_in_2    (d_in_2),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .z_flag    (z_flag),
        .a_grt_b   (a_grt_b),
        .b_grt_a   (b_grt_a),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference behaviour from the arithmetic definition of each opcode
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        e.z = (ua == ub); e.gt = (ua > ub); e.lt = (ua < ub);
        e.err = 1'b0; e.lat = 1; e.acc_cyc = 0; e.seen = 0;
        e.d = '0;
        case (op)
            3'd0: e.d = W'((ua + ub) % MOD);
            3'd1: begin e.d = W'((ua * ub) % MOD); e.lat = W + 1; end
            3'd2: e.d = a & b;
            3'd3: e.d = a | b;
            3'd4: begin
`ifdef ALU_SEQ_DIV_EN
                if (ub == 0) begin e.d = '1; e.err = 1'b1; end
                else begin e.d = W'(ua / ub); e.lat = W + 1; end
`else
                e.d = W'(ua / 2);
`endif
            end
            3'd5: e.d = W'(ua > ub);
            3'd6: e.d = W'(ua < ub);
            default: e.d = (ub >= 64'(W)) ? '0 : W'((ua * (64'd1 << ub)) % MOD);
        endcase
        return e;
    endfunction

    // Consumer backpressure, changed away from the sampling edges
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("in_ready", 64'(in_ready), 64'(sb.size() == 0));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb[0];
                    if (!mon_e.seen) begin
                        chk("latency", 64'(cyc - mon_e.acc_cyc + 1), 64'(mon_e.lat));
                        sb[0].seen = 1'b1;
                    end
                    chk("d_out",   64'(d_out),   64'(mon_e.d));
                    chk("z_flag",  64'(z_flag),  64'(mon_e.z));
                    chk("a_grt_b", 64'(a_grt_b), 64'(mon_e.gt));
                    chk("b_grt_a", 64'(b_grt_a), 64'(mon_e.lt));
                    chk("div_err", 64'(div_err), 64'(mon_e.err));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic garbage();
        in_valid = 1'($urandom);
        alu_op   = 3'($urandom);
        d_in_1   = W'($urandom);
        d_in_2   = W'($urandom);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            garbage();
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("issue_timeout_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1; alu_op = op; d_in_1 = a; d_in_2 = b;
        e = model(op, a, b);
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        alu_op = 3'($urandom); d_in_1 = W'($urandom); d_in_2 = W'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sb.size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_d_out"},     64'(d_out),     64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_z_flag"},    64'(z_flag),    64'd0);
        chk({tag, "_a_grt_b"},   64'(a_grt_b),   64'd0);
        chk({tag, "_b_grt_a"},   64'(b_grt_a),   64'd0);
        chk({tag, "_div_err"},   64'(div_err),   64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] ra, rb;
        int           g;

        in_valid = 1'b0; alu_op = '0; d_in_1 = '0; d_in_2 = '0; out_ready = 1'b1;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_checks("por");
        @(posedge clk);
        #3 rst = 1'b0;

        bp_mode = 1;
        issue(3'd0, 16'hFFFF, 16'h0002);
        issue(3'd1, 16'h0123, 16'h0045);
        issue(3'd4, 16'h00C8, 16'h0007);
        issue(3'd4, 16'h1234, 16'h0000);
        issue(3'd7, 16'h0001, 16'd16);
        issue(3'd7, 16'h0001, 16'd15);
        issue(3'd6, 16'h0003, 16'h0005);
        issue(3'd2, 16'hA5A5, 16'hA5A5);
        drain();

        // Result must hold under backpressure while new requests are offered
        bp_mode = 2;
        issue(3'd5, 16'h0005, 16'h0003);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("hold_reached", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            garbage();
            in_valid = 1'b1;
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        bp_mode = 1;
        drain();

        // Abort a multiply partway through
        issue(3'd1, 16'h1111, 16'h0003);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        #1 reset_checks("abort");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("post_abort_out_valid", 64'(out_valid), 64'd0);
        end
        issue(3'd0, 16'h0002, 16'h0002);
        drain();

        bp_mode = 0;
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = ra;
                2: rb = W'($urandom_range(0, 20));
                3: begin ra = W'($urandom_range(0, 15)); rb = W'($urandom_range(0, 15)); end
                default: ;
            endcase
            issue(op, ra, rb);
        end
        bp_mode = 1;
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal 4..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 d_in_1  input  WIDTH  operand A.
REQ-007 d_in_2  input  WIDTH  operand B.
REQ-008 alu_op  input  3  000 add, 001 mul, 010 and, 011 or, 100 div, 101 A>B, 110 A<B, 111 shl.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 d_out  output  WIDTH  registered result.
REQ-012 z_flag, a_grt_b, b_grt_a  output  1 each  registered compare flags of captured A,B.
REQ-013 div_err  output  1  registered; set for divide by zero.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept on in_valid&in_ready edge: operands and opcode captured into internal registers; later input changes ignored.
REQ-016 Single-cycle ops (add, and, or, cmp, shl): IDLE->DONE; out_valid asserted the cycle after acceptance.
REQ-017 mul, div: IDLE->BUSY; iterative, one bit per cycle; BUSY lasts exactly WIDTH cycles; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-018 DONE->IDLE on out_ready; d_out and flags SHALL hold stable while out_valid&!out_ready.
REQ-019 No new acceptance in the cycle DONE completes; next acceptance earliest one cycle after handshake.
REQ-020 add: low WIDTH bits of A+B, carry discarded; mul: low WIDTH bits of A*B, unsigned.
REQ-021 div: unsigned quotient A/B truncated, restoring algorithm; B==0 -> d_out all ones, div_err=1, completes via IDLE->DONE in one cycle.
REQ-022 cmp ops: d_out[0]=result, d_out[WIDTH-1:1]=0.
REQ-023 shl: A<<B; B>=WIDTH -> d_out=0.
REQ-024 Flags for every op: a_grt_b=(A>B), b_grt_a=(A<B), z_flag=(A==B), exactly one set; div_err=0 except REQ-021.

Reset
REQ-025 rst SHALL force IDLE, d_out=0, out_valid=0, in_ready=1 after release, z_flag=a_grt_b=b_grt_a=div_err=0, iteration counter=0.
REQ-026 rst during BUSY or DONE SHALL abort the operation; no result produced afterward.

Configuration
REQ-027 Macro ALU_SEQ_DIV_EN defined: op 100 is the iterative divider per REQ-017/021.
REQ-028 Macro undefined: divider logic absent; op 100 yields A>>1 as single-cycle op, div_err tied 0.

Structure
REQ-029 Package alu_pkg holds opcode constants and FSM state encoding, shared with the decoder.
REQ-030 Sub-module alu_muldiv_iter holds shift-add multiplier, restoring divider and iteration counter; top holds FSM, single-cycle datapath and output registers.

Verification (WIDTH=16)
REQ-031 add 0xFFFF+0x0002 -> d_out=0x0001 one cycle after accept, b_grt_a=0, a_grt_b=1.
REQ-032 mul 0x0123*0x0045 -> d_out=0x4E6F exactly 17 cycles after accept; in_ready=0 throughout.
REQ-033 div 0x00C8/0x0007 -> d_out=0x001C, div_err=0; div 0x1234/0 -> d_out=0xFFFF, div_err=1.
REQ-034 out_ready held 0 for 5 cycles after cmp 5>3 -> d_out=0x0001, flags stable, in_valid ignored until handshake.
REQ-035 rst asserted mid-mul (cycle 8) -> out_valid stays 0, outputs zero, next add 2+2 -> 0x0004.
REQ-036 shl 0x0001<<16 -> 0x0000; shl 0x0001<<15 -> 0x8000.
